// File: rtl/rv32i_types.sv
// Shared RV32I core types: branch funct3 encodings plus the branch-resolve
// controller's kind/state enums and latched request record.
package rv32i_types;

  localparam logic [2:0] branch_f3_beq  = 3'b000;
  localparam logic [2:0] branch_f3_bne  = 3'b001;
  localparam logic [2:0] branch_f3_blt  = 3'b100;
  localparam logic [2:0] branch_f3_bge  = 3'b101;
  localparam logic [2:0] branch_f3_bltu = 3'b110;
  localparam logic [2:0] branch_f3_bgeu = 3'b111;

  typedef enum logic [1:0] {
    BR_COND = 2'd0,
    BR_JAL  = 2'd1,
    BR_JALR = 2'd2
  } br_kind_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EVAL,
    S_REDIRECT
  } br_state_t;

  typedef struct packed {
    br_kind_t    kind;
    logic [2:0]  funct3;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1_v;
    logic [31:0] rs2_v;
    logic        pred_taken;
    logic [31:0] pred_target;
  } br_req_t;

  // funct3 010/011 have no conditional-branch meaning in RV32I.
  function automatic logic f3_is_illegal(input logic [2:0] f3);
    return (f3 == 3'b010) || (f3 == 3'b011);
  endfunction

endpackage

// File: rtl/br_resolve_ctrl_if.sv
// Bundle of the ID/EX request, fetch redirect, predictor update and
// statistics signals around the branch-resolve controller.
interface br_resolve_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  import rv32i_types::*;

  logic             in_valid;
  logic             in_ready;
  br_kind_t         in_kind;
  logic [2:0]       in_funct3;
  logic [31:0]      in_pc;
  logic [31:0]      in_imm;
  logic [31:0]      in_rs1_v;
  logic [31:0]      in_rs2_v;
  logic             in_pred_taken;
  logic [31:0]      in_pred_target;
  logic             ext_flush;
  logic             redirect_valid;
  logic             redirect_ready;
  logic [31:0]      redirect_pc;
  logic             flush;
  logic             upd_valid;
  logic [31:0]      upd_pc;
  logic             upd_taken;
  logic [31:0]      upd_target;
  logic             illegal_f3;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] mis_count;

  modport master (
    output in_valid, in_kind, in_funct3, in_pc, in_imm, in_rs1_v, in_rs2_v,
           in_pred_taken, in_pred_target, ext_flush, redirect_ready,
    input  in_ready, redirect_valid, redirect_pc, flush, upd_valid, upd_pc,
           upd_taken, upd_target, illegal_f3, br_count, mis_count
  );

  modport slave (
    input  in_valid, in_kind, in_funct3, in_pc, in_imm, in_rs1_v, in_rs2_v,
           in_pred_taken, in_pred_target, ext_flush, redirect_ready,
    output in_ready, redirect_valid, redirect_pc, flush, upd_valid, upd_pc,
           upd_taken, upd_target, illegal_f3, br_count, mis_count
  );

endinterface

// File: rtl/branch.sv
// RV32I conditional-branch comparator: br_en is the taken condition for the
// given funct3; undefined encodings report not-taken.
module branch
  import rv32i_types::*;
(
  input  logic [2:0]  cmpop,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        br_en
);

  always_comb begin
    case (cmpop)
      branch_f3_beq:  br_en = (a == b);
      branch_f3_bne:  br_en = (a != b);
      branch_f3_blt:  br_en = ($signed(a) <  $signed(b));
      branch_f3_bge:  br_en = ($signed(a) >= $signed(b));
      branch_f3_bltu: br_en = (a <  b);
      branch_f3_bgeu: br_en = (a >= b);
      default:        br_en = 1'b0;
    endcase
  end

endmodule

// File: rtl/br_resolve_ctrl.sv
// EX-stage branch/jump resolution: latches one op, evaluates it against the
// fetch prediction, then emits predictor update, flush and fetch redirect.
module br_resolve_ctrl
  import rv32i_types::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  br_resolve_ctrl_if.slave bus
);

  br_state_t        state_q, state_d;
  br_req_t          req_q, req_d;
  logic             in_ready_q, in_ready_d;
  logic             redirect_valid_q, redirect_valid_d;
  logic [31:0]      redirect_pc_q, redirect_pc_d;
  logic             flush_q, flush_d;
  logic             upd_valid_q, upd_valid_d;
  logic [31:0]      upd_pc_q, upd_pc_d;
  logic             upd_taken_q, upd_taken_d;
  logic [31:0]      upd_target_q, upd_target_d;
  logic             illegal_f3_q, illegal_f3_d;
  logic [CNT_W-1:0] br_count_q, br_count_d;
  logic [CNT_W-1:0] mis_count_q, mis_count_d;

  logic             br_en;
  logic             illegal;
  logic             taken;
  logic [31:0]      target;
  logic             mispredict;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Comparator sees only latched operands, keeping the ID/EX path off it.
  branch u_branch (
    .cmpop (req_q.funct3),
    .a     (req_q.rs1_v),
    .b     (req_q.rs2_v),
    .br_en (br_en)
  );

  always_comb begin
    illegal = (req_q.kind == BR_COND) && f3_is_illegal(req_q.funct3);
    taken   = 1'b1;
    target  = req_q.pc + req_q.imm;
    case (req_q.kind)
      BR_COND: taken  = br_en && !illegal;
      BR_JALR: target = (req_q.rs1_v + req_q.imm) & ~32'd1;
      default: taken  = 1'b1;
    endcase
    mispredict = (taken != req_q.pred_taken) ||
                 (taken && (target != req_q.pred_target));
  end

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    state_d          = state_q;
    req_d            = req_q;
    in_ready_d       = in_ready_q;
    redirect_valid_d = redirect_valid_q;
    redirect_pc_d    = redirect_pc_q;
    flush_d          = 1'b0;
    upd_valid_d      = 1'b0;
    upd_pc_d         = upd_pc_q;
    upd_taken_d      = upd_taken_q;
    upd_target_d     = upd_target_q;
    illegal_f3_d     = 1'b0;
    br_count_d       = br_count_q;
    mis_count_d      = mis_count_q;

    if (bus.ext_flush) begin
      // An older kill discards whatever is in flight, including a pending redirect.
      state_d          = S_IDLE;
      in_ready_d       = 1'b1;
      redirect_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            req_d = '{kind:        bus.in_kind,
                      funct3:      bus.in_funct3,
                      pc:          bus.in_pc,
                      imm:         bus.in_imm,
                      rs1_v:       bus.in_rs1_v,
                      rs2_v:       bus.in_rs2_v,
                      pred_taken:  bus.in_pred_taken,
                      pred_target: bus.in_pred_target};
            state_d    = S_EVAL;
            in_ready_d = 1'b0;
          end
        end
        S_EVAL: begin
          upd_valid_d  = 1'b1;
          upd_pc_d     = req_q.pc;
          upd_taken_d  = taken;
          upd_target_d = target;
          illegal_f3_d = illegal;
          br_count_d   = sat_inc(br_count_q);
          if (mispredict) begin
            mis_count_d      = sat_inc(mis_count_q);
            flush_d          = 1'b1;
            redirect_valid_d = 1'b1;
            redirect_pc_d    = taken ? target : req_q.pc + 32'd4;
            state_d          = S_REDIRECT;
          end else begin
            state_d    = S_IDLE;
            in_ready_d = 1'b1;
          end
        end
        S_REDIRECT: begin
          if (bus.redirect_ready) begin
            redirect_valid_d = 1'b0;
            state_d          = S_IDLE;
            in_ready_d       = 1'b1;
          end
        end
        default: begin
          state_d          = S_IDLE;
          in_ready_d       = 1'b1;
          redirect_valid_d = 1'b0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= S_IDLE;
      req_q            <= '0;
      in_ready_q       <= 1'b1;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      flush_q          <= 1'b0;
      upd_valid_q      <= 1'b0;
      upd_pc_q         <= '0;
      upd_taken_q      <= 1'b0;
      upd_target_q     <= '0;
      illegal_f3_q     <= 1'b0;
      br_count_q       <= '0;
      mis_count_q      <= '0;
    end else begin
      state_q          <= state_d;
      req_q            <= req_d;
      in_ready_q       <= in_ready_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      flush_q          <= flush_d;
      upd_valid_q      <= upd_valid_d;
      upd_pc_q         <= upd_pc_d;
      upd_taken_q      <= upd_taken_d;
      upd_target_q     <= upd_target_d;
      illegal_f3_q     <= illegal_f3_d;
      br_count_q       <= br_count_d;
      mis_count_q      <= mis_count_d;
    end
  end

  assign bus.in_ready       = in_ready_q;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.flush          = flush_q;
  assign bus.upd_valid      = upd_valid_q;
  assign bus.upd_pc         = upd_pc_q;
  assign bus.upd_taken      = upd_taken_q;
  assign bus.upd_target     = upd_target_q;
  assign bus.illegal_f3     = illegal_f3_q;
  assign bus.br_count       = br_count_q;
  assign bus.mis_count      = mis_count_q;

endmodule

// File: tb/tb_br_resolve_ctrl.sv
// Self-checking bench for br_resolve_ctrl: directed scenarios plus randomized
// ops against a rule-level reference model; a 3-bit instance checks saturation.
module tb_br_resolve_ctrl;
  import rv32i_types::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  br_resolve_ctrl_if #(.CNT_W(32)) bif ();
  br_resolve_ctrl_if #(.CNT_W(3))  sif ();

  assign sif.in_valid       = bif.in_valid;
  assign sif.in_kind        = bif.in_kind;
  assign sif.in_funct3      = bif.in_funct3;
  assign sif.in_pc          = bif.in_pc;
  assign sif.in_imm         = bif.in_imm;
  assign sif.in_rs1_v       = bif.in_rs1_v;
  assign sif.in_rs2_v       = bif.in_rs2_v;
  assign sif.in_pred_taken  = bif.in_pred_taken;
  assign sif.in_pred_target = bif.in_pred_target;
  assign sif.ext_flush      = bif.ext_flush;
  assign sif.redirect_ready = bif.redirect_ready;

  br_resolve_ctrl #(.CNT_W(32)) dut     (.clk(clk), .rst(rst), .bus(bif.slave));
  br_resolve_ctrl #(.CNT_W(3))  dut_sat (.clk(clk), .rst(rst), .bus(sif.slave));

  int errors = 0;
  int checks = 0;
  int exp_br = 0;
  int exp_mis = 0;

  typedef struct {
    logic        taken;
    logic [31:0] target;
    logic        mis;
    logic        ill;
    logic [31:0] rpc;
  } res_t;

  // Resolution rules computed straight from the ISA semantics.
  function automatic res_t model(input br_kind_t kind, input logic [2:0] f3,
                                 input logic [31:0] pc, input logic [31:0] imm,
                                 input logic [31:0] rs1, input logic [31:0] rs2,
                                 input logic pt, input logic [31:0] ptgt);
    res_t r;
    r.ill    = 1'b0;
    r.taken  = 1'b1;
    r.target = pc + imm;
    if (kind == BR_JALR) r.target = (rs1 + imm) & 32'hFFFF_FFFE;
    if (kind == BR_COND) begin
      case (f3)
        3'd0: r.taken = (rs1 == rs2);
        3'd1: r.taken = (rs1 != rs2);
        3'd4: r.taken = ($signed(rs1) <  $signed(rs2));
        3'd5: r.taken = ($signed(rs1) >= $signed(rs2));
        3'd6: r.taken = (rs1 <  rs2);
        3'd7: r.taken = (rs1 >= rs2);
        default: begin r.taken = 1'b0; r.ill = 1'b1; end
      endcase
    end
    r.mis = (r.taken != pt) || (r.taken && (r.target != ptgt));
    r.rpc = r.taken ? r.target : pc + 32'd4;
    return r;
  endfunction

  function automatic logic [2:0] sat3(input int v);
    return (v > 7) ? 3'd7 : 3'(v);
  endfunction

  // Called at a falling edge with the DUT idle; returns at the falling edge of N+2.
  task automatic issue(input br_kind_t kind, input logic [2:0] f3,
                       input logic [31:0] pc, input logic [31:0] imm,
                       input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic pt, input logic [31:0] ptgt);
    bif.in_valid       = 1'b1;
    bif.in_kind        = kind;
    bif.in_funct3      = f3;
    bif.in_pc          = pc;
    bif.in_imm         = imm;
    bif.in_rs1_v       = rs1;
    bif.in_rs2_v       = rs2;
    bif.in_pred_taken  = pt;
    bif.in_pred_target = ptgt;
    @(posedge clk);
    @(negedge clk);
    bif.in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    bif.in_valid = 1'b0; bif.in_kind = BR_COND; bif.in_funct3 = 3'd0;
    bif.in_pc = '0; bif.in_imm = '0; bif.in_rs1_v = '0; bif.in_rs2_v = '0;
    bif.in_pred_taken = 1'b0; bif.in_pred_target = '0;
    bif.ext_flush = 1'b0; bif.redirect_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++;
    if ({bif.in_ready, bif.redirect_valid, bif.flush, bif.upd_valid, bif.upd_taken, bif.illegal_f3} !== 6'b100000) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 100000",
        {bif.in_ready, bif.redirect_valid, bif.flush, bif.upd_valid, bif.upd_taken, bif.illegal_f3});
    end
    checks++;
    if ({bif.redirect_pc, bif.upd_pc, bif.upd_target, bif.br_count, bif.mis_count} !== '0) begin
      errors++; $display("FAIL reset_data: rpc=%h upd_pc=%h upd_tgt=%h br=%0d mis=%0d expected all 0",
        bif.redirect_pc, bif.upd_pc, bif.upd_target, bif.br_count, bif.mis_count);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_beq();
    issue(BR_COND, 3'b000, 32'h200, 32'h40, 32'd5, 32'd5, 1'b1, 32'h240);
    exp_br++;
    checks++;
    if ({bif.upd_valid, bif.upd_taken, bif.redirect_valid, bif.flush, bif.in_ready} !== 5'b11001) begin
      errors++; $display("FAIL beq_ctrl: got %b expected 11001",
        {bif.upd_valid, bif.upd_taken, bif.redirect_valid, bif.flush, bif.in_ready});
    end
    checks++;
    if (bif.upd_pc !== 32'h200 || bif.upd_target !== 32'h240) begin
      errors++; $display("FAIL beq_upd: pc=%h tgt=%h expected 00000200/00000240", bif.upd_pc, bif.upd_target);
    end
    checks++;
    if (bif.br_count !== 32'd1 || bif.mis_count !== 32'd0) begin
      errors++; $display("FAIL beq_counts: br=%0d mis=%0d expected 1/0", bif.br_count, bif.mis_count);
    end
    @(negedge clk);
    checks++;
    if (bif.upd_valid !== 1'b0) begin
      errors++; $display("FAIL beq_upd_pulse: upd_valid=%b expected 0", bif.upd_valid);
    end
  endtask

  task automatic test_back_to_back();
    issue(BR_JAL, 3'd0, 32'h500, 32'h8, 32'd0, 32'd0, 1'b1, 32'h508);
    exp_br++;
    checks++;
    if (bif.in_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_ready: in_ready=%b expected 1", bif.in_ready);
    end
    issue(BR_COND, 3'b001, 32'h600, 32'hFFFF_FFF0, 32'd1, 32'd2, 1'b1, 32'h5F0);
    exp_br++;
    checks++;
    if (bif.upd_valid !== 1'b1 || bif.upd_pc !== 32'h600 || bif.upd_target !== 32'h5F0 || bif.redirect_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_second: upd_valid=%b pc=%h tgt=%h rv=%b expected 1/00000600/000005f0/0",
        bif.upd_valid, bif.upd_pc, bif.upd_target, bif.redirect_valid);
    end
    checks++;
    if (bif.br_count !== 32'(exp_br)) begin
      errors++; $display("FAIL b2b_count: br=%0d expected %0d", bif.br_count, exp_br);
    end
  endtask

  task automatic test_blt_bltu();
    issue(BR_COND, 3'b100, 32'h100, 32'h20, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0);
    exp_br++; exp_mis++;
    checks++;
    if (bif.redirect_valid !== 1'b1 || bif.redirect_pc !== 32'h120 || bif.flush !== 1'b1) begin
      errors++; $display("FAIL blt_redirect: rv=%b rpc=%h flush=%b expected 1/00000120/1",
        bif.redirect_valid, bif.redirect_pc, bif.flush);
    end
    checks++;
    if (bif.mis_count !== 32'(exp_mis) || bif.br_count !== 32'(exp_br)) begin
      errors++; $display("FAIL blt_counts: br=%0d mis=%0d expected %0d/%0d", bif.br_count, bif.mis_count, exp_br, exp_mis);
    end
    bif.redirect_ready = 1'b1;
    @(negedge clk);
    bif.redirect_ready = 1'b0;
    checks++;
    if (bif.flush !== 1'b0 || bif.redirect_valid !== 1'b0 || bif.in_ready !== 1'b1) begin
      errors++; $display("FAIL blt_after: flush=%b rv=%b in_ready=%b expected 0/0/1",
        bif.flush, bif.redirect_valid, bif.in_ready);
    end
    issue(BR_COND, 3'b110, 32'h100, 32'h20, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0);
    exp_br++;
    checks++;
    if (bif.upd_taken !== 1'b0 || bif.redirect_valid !== 1'b0 || bif.flush !== 1'b0 || bif.upd_target !== 32'h120) begin
      errors++; $display("FAIL bltu: taken=%b rv=%b flush=%b tgt=%h expected 0/0/0/00000120",
        bif.upd_taken, bif.redirect_valid, bif.flush, bif.upd_target);
    end
  endtask

  task automatic test_jalr();
    issue(BR_JALR, 3'd0, 32'h300, 32'h0, 32'h1003, 32'h0, 1'b1, 32'h1002);
    exp_br++;
    checks++;
    if (bif.upd_target !== 32'h1002 || bif.upd_taken !== 1'b1 || bif.redirect_valid !== 1'b0) begin
      errors++; $display("FAIL jalr_hit: tgt=%h taken=%b rv=%b expected 00001002/1/0",
        bif.upd_target, bif.upd_taken, bif.redirect_valid);
    end
    issue(BR_JALR, 3'd0, 32'h300, 32'h0, 32'h1003, 32'h0, 1'b1, 32'h2000);
    exp_br++; exp_mis++;
    checks++;
    if (bif.redirect_valid !== 1'b1 || bif.redirect_pc !== 32'h1002) begin
      errors++; $display("FAIL jalr_miss: rv=%b rpc=%h expected 1/00001002", bif.redirect_valid, bif.redirect_pc);
    end
    bif.redirect_ready = 1'b1;
    @(negedge clk);
    bif.redirect_ready = 1'b0;
  endtask

  task automatic test_redirect_stall();
    issue(BR_JAL, 3'd0, 32'h400, 32'h10, 32'd0, 32'd0, 1'b0, 32'h0);
    exp_br++; exp_mis++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bif.redirect_valid !== 1'b1 || bif.redirect_pc !== 32'h410 || bif.in_ready !== 1'b0 || bif.flush !== (i == 0)) begin
        errors++; $display("FAIL stall_cycle%0d: rv=%b rpc=%h in_ready=%b flush=%b expected 1/00000410/0/%b",
          i, bif.redirect_valid, bif.redirect_pc, bif.in_ready, bif.flush, (i == 0));
      end
      bif.redirect_ready = (i == 3);
      @(negedge clk);
    end
    bif.redirect_ready = 1'b0;
    checks++;
    if (bif.redirect_valid !== 1'b0 || bif.in_ready !== 1'b1) begin
      errors++; $display("FAIL stall_release: rv=%b in_ready=%b expected 0/1", bif.redirect_valid, bif.in_ready);
    end
    // Target wraps past 2^32; redirect_ready already high gives a 1-cycle redirect.
    bif.redirect_ready = 1'b1;
    issue(BR_JAL, 3'd0, 32'hFFFF_FFFC, 32'h8, 32'd0, 32'd0, 1'b0, 32'h0);
    exp_br++; exp_mis++;
    checks++;
    if (bif.redirect_valid !== 1'b1 || bif.redirect_pc !== 32'h4) begin
      errors++; $display("FAIL wrap_redirect: rv=%b rpc=%h expected 1/00000004", bif.redirect_valid, bif.redirect_pc);
    end
    @(negedge clk);
    bif.redirect_ready = 1'b0;
    checks++;
    if (bif.redirect_valid !== 1'b0 || bif.in_ready !== 1'b1) begin
      errors++; $display("FAIL wrap_min_dur: rv=%b in_ready=%b expected 0/1", bif.redirect_valid, bif.in_ready);
    end
  endtask

  task automatic test_ext_flush();
    // Kill during S_EVAL with an op that would otherwise pulse everything.
    bif.in_valid = 1'b1; bif.in_kind = BR_COND; bif.in_funct3 = 3'b010;
    bif.in_pc = 32'h700; bif.in_imm = 32'h4; bif.in_pred_taken = 1'b1; bif.in_pred_target = 32'h704;
    @(posedge clk);
    @(negedge clk);
    bif.in_valid = 1'b0;
    bif.ext_flush = 1'b1;
    @(negedge clk);
    bif.ext_flush = 1'b0;
    checks++;
    if ({bif.upd_valid, bif.flush, bif.illegal_f3, bif.redirect_valid, bif.in_ready} !== 5'b00001) begin
      errors++; $display("FAIL xflush_eval: upd/flush/ill/rv/ready=%b expected 00001",
        {bif.upd_valid, bif.flush, bif.illegal_f3, bif.redirect_valid, bif.in_ready});
    end
    checks++;
    if (bif.br_count !== 32'(exp_br) || bif.mis_count !== 32'(exp_mis)) begin
      errors++; $display("FAIL xflush_eval_counts: br=%0d mis=%0d expected %0d/%0d", bif.br_count, bif.mis_count, exp_br, exp_mis);
    end
    // Kill during S_REDIRECT.
    issue(BR_COND, 3'b000, 32'h800, 32'h10, 32'd1, 32'd1, 1'b0, 32'h0);
    exp_br++; exp_mis++;
    bif.ext_flush = 1'b1;
    @(negedge clk);
    bif.ext_flush = 1'b0;
    checks++;
    if (bif.redirect_valid !== 1'b0 || bif.in_ready !== 1'b1 || bif.flush !== 1'b0) begin
      errors++; $display("FAIL xflush_redir: rv=%b in_ready=%b flush=%b expected 0/1/0", bif.redirect_valid, bif.in_ready, bif.flush);
    end
    checks++;
    if (bif.br_count !== 32'(exp_br) || bif.mis_count !== 32'(exp_mis)) begin
      errors++; $display("FAIL xflush_redir_counts: br=%0d mis=%0d expected %0d/%0d", bif.br_count, bif.mis_count, exp_br, exp_mis);
    end
    // in_valid together with ext_flush in S_IDLE is not accepted.
    bif.in_valid = 1'b1; bif.ext_flush = 1'b1;
    @(negedge clk);
    bif.in_valid = 1'b0; bif.ext_flush = 1'b0;
    checks++;
    if (bif.in_ready !== 1'b1) begin
      errors++; $display("FAIL xflush_idle_ready: in_ready=%b expected 1", bif.in_ready);
    end
    @(negedge clk);
    checks++;
    if (bif.upd_valid !== 1'b0 || bif.redirect_valid !== 1'b0 || bif.br_count !== 32'(exp_br)) begin
      errors++; $display("FAIL xflush_idle_noop: upd=%b rv=%b br=%0d expected 0/0/%0d", bif.upd_valid, bif.redirect_valid, bif.br_count, exp_br);
    end
  endtask

  task automatic test_illegal();
    issue(BR_COND, 3'b010, 32'h40, 32'h80, 32'd3, 32'd3, 1'b1, 32'hC0);
    exp_br++; exp_mis++;
    checks++;
    if ({bif.illegal_f3, bif.upd_taken, bif.redirect_valid, bif.flush} !== 4'b1011 || bif.redirect_pc !== 32'h44) begin
      errors++; $display("FAIL illegal_010: ill/taken/rv/flush=%b rpc=%h expected 1011/00000044",
        {bif.illegal_f3, bif.upd_taken, bif.redirect_valid, bif.flush}, bif.redirect_pc);
    end
    bif.redirect_ready = 1'b1;
    @(negedge clk);
    bif.redirect_ready = 1'b0;
    checks++;
    if (bif.illegal_f3 !== 1'b0) begin
      errors++; $display("FAIL illegal_pulse: ill=%b expected 0", bif.illegal_f3);
    end
    issue(BR_COND, 3'b011, 32'h50, 32'h80, 32'd1, 32'd9, 1'b0, 32'h0);
    exp_br++;
    checks++;
    if (bif.illegal_f3 !== 1'b1 || bif.redirect_valid !== 1'b0 || bif.upd_taken !== 1'b0) begin
      errors++; $display("FAIL illegal_011: ill=%b rv=%b taken=%b expected 1/0/0", bif.illegal_f3, bif.redirect_valid, bif.upd_taken);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      br_kind_t    kind = br_kind_t'($urandom_range(0, 2));
      logic [2:0]  f3   = 3'($urandom_range(0, 7));
      logic [31:0] pc   = $urandom() & 32'hFFFF_FFFC;
      logic [31:0] imm  = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 255)) - 32'd128 : $urandom();
      logic [31:0] rs1  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom();
      logic [31:0] rs2  = ($urandom_range(0, 2) == 0) ? rs1 : $urandom();
      logic        pt   = 1'($urandom_range(0, 1));
      logic [31:0] ptgt;
      int          k    = $urandom_range(0, 2);
      res_t        r    = model(kind, f3, pc, imm, rs1, rs2, pt, 32'h0);
      ptgt = ($urandom_range(0, 3) != 0) ? r.target : $urandom();
      r    = model(kind, f3, pc, imm, rs1, rs2, pt, ptgt);
      issue(kind, f3, pc, imm, rs1, rs2, pt, ptgt);
      exp_br++;
      if (r.mis) exp_mis++;
      checks++;
      if ({bif.upd_valid, bif.upd_taken, bif.illegal_f3, bif.flush, bif.redirect_valid, bif.in_ready} !==
          {1'b1, r.taken, r.ill, r.mis, r.mis, !r.mis}) begin
        errors++; $display("FAIL rand%0d_ctrl: upd/taken/ill/flush/rv/ready=%b expected %b", n,
          {bif.upd_valid, bif.upd_taken, bif.illegal_f3, bif.flush, bif.redirect_valid, bif.in_ready},
          {1'b1, r.taken, r.ill, r.mis, r.mis, !r.mis});
      end
      checks++;
      if (bif.upd_pc !== pc || bif.upd_target !== r.target || (r.mis && bif.redirect_pc !== r.rpc)) begin
        errors++; $display("FAIL rand%0d_data: pc=%h tgt=%h rpc=%h expected %h/%h/%h", n,
          bif.upd_pc, bif.upd_target, bif.redirect_pc, pc, r.target, r.rpc);
      end
      checks++;
      if (bif.br_count !== 32'(exp_br) || bif.mis_count !== 32'(exp_mis) ||
          sif.br_count !== sat3(exp_br) || sif.mis_count !== sat3(exp_mis)) begin
        errors++; $display("FAIL rand%0d_counts: br=%0d mis=%0d sat_br=%0d sat_mis=%0d expected %0d/%0d/%0d/%0d", n,
          bif.br_count, bif.mis_count, sif.br_count, sif.mis_count, exp_br, exp_mis, sat3(exp_br), sat3(exp_mis));
      end
      if (r.mis) begin
        for (int i = 0; i <= k; i++) begin
          if (i > 0) begin
            checks++;
            if (bif.redirect_valid !== 1'b1 || bif.redirect_pc !== r.rpc || bif.flush !== 1'b0) begin
              errors++; $display("FAIL rand%0d_hold%0d: rv=%b rpc=%h flush=%b expected 1/%h/0", n, i,
                bif.redirect_valid, bif.redirect_pc, bif.flush, r.rpc);
            end
          end
          bif.redirect_ready = (i == k);
          @(negedge clk);
        end
        bif.redirect_ready = 1'b0;
        checks++;
        if (bif.redirect_valid !== 1'b0 || bif.in_ready !== 1'b1) begin
          errors++; $display("FAIL rand%0d_release: rv=%b in_ready=%b expected 0/1", n, bif.redirect_valid, bif.in_ready);
        end
      end
    end
  endtask

  task automatic test_saturation();
    // The 3-bit instance has seen far more than 7 ops by now; one more must hold at all-ones.
    issue(BR_JAL, 3'd0, 32'h900, 32'h4, 32'd0, 32'd0, 1'b0, 32'h0);
    exp_br++; exp_mis++;
    checks++;
    if (sif.br_count !== 3'd7 || sif.mis_count !== sat3(exp_mis)) begin
      errors++; $display("FAIL sat_hold: br=%0d mis=%0d expected 7/%0d", sif.br_count, sif.mis_count, sat3(exp_mis));
    end
    checks++;
    if (bif.br_count !== 32'(exp_br)) begin
      errors++; $display("FAIL sat_wide: br=%0d expected %0d", bif.br_count, exp_br);
    end
    bif.redirect_ready = 1'b1;
    @(negedge clk);
    bif.redirect_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    issue(BR_JAL, 3'd0, 32'hA00, 32'h4, 32'd0, 32'd0, 1'b0, 32'h0);
    checks++;
    if (bif.redirect_valid !== 1'b1) begin
      errors++; $display("FAIL areset_pre: rv=%b expected 1", bif.redirect_valid);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bif.redirect_valid !== 1'b0 || bif.br_count !== 32'd0 || bif.mis_count !== 32'd0 || bif.in_ready !== 1'b1) begin
      errors++; $display("FAIL areset_now: rv=%b br=%0d mis=%0d in_ready=%b expected 0/0/0/1",
        bif.redirect_valid, bif.br_count, bif.mis_count, bif.in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_br = 0; exp_mis = 0;
  endtask

  initial begin
    test_reset();
    test_beq();
    test_back_to_back();
    test_blt_bltu();
    test_jalr();
    test_redirect_stall();
    test_ext_flush();
    test_illegal();
    test_random();
    test_saturation();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
